// File: rtl/axi_rab_pkg.sv
// Shared definitions for the AXI remapping/blocking R-channel logic:
// sender FSM states and AXI error response codes.
package axi_rab_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_ERR  = 2'd2
  } rrch_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4_rrch_sender_if.sv
// AXI4 R-channel bundle. Handshake: a beat transfers on a rising clock edge
// where rvalid and rready are both high; once rvalid is raised the payload
// holds stable until that transfer.
interface axi4_rrch_sender_if #(
  parameter int DW = 32,
  parameter int IW = 4,
  parameter int UW = 4
);
  logic [IW-1:0] rid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic [UW-1:0] ruser;
  logic          rvalid;
  logic          rready;

  modport master (output rid, rdata, rresp, rlast, ruser, rvalid, input rready);
  modport slave  (input rid, rdata, rresp, rlast, ruser, rvalid, output rready);
endinterface

// File: rtl/axi4_drop_fifo.sv
// Small FIFO holding pending error-burst requests. A push is taken while full
// if a pop happens in the same cycle.
module axi4_drop_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/axi4_rrch_sender.sv
// Merges the downstream R channel with locally generated error bursts.
// Queued error bursts win arbitration in IDLE; passthrough bursts are never split.
module axi4_rrch_sender
  import axi_rab_pkg::*;
#(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ID_WIDTH   = 4,
  parameter int C_AXI_USER_WIDTH = 4,
  parameter int C_DROP_DEPTH     = 2
) (
  input  logic                        axi4_aclk,
  input  logic                        axi4_arstn,
  input  logic                        drop_valid,
  output logic                        drop_ready,
  input  logic [C_AXI_ID_WIDTH-1:0]   drop_id,
  input  logic [7:0]                  drop_len,
  input  logic [C_AXI_USER_WIDTH-1:0] drop_user,
  input  logic [1:0]                  drop_resp,
  input  logic [C_AXI_ID_WIDTH-1:0]   m_axi4_rid,
  input  logic [C_AXI_DATA_WIDTH-1:0] m_axi4_rdata,
  input  logic [1:0]                  m_axi4_rresp,
  input  logic                        m_axi4_rlast,
  input  logic [C_AXI_USER_WIDTH-1:0] m_axi4_ruser,
  input  logic                        m_axi4_rvalid,
  output logic                        m_axi4_rready,
  output logic [C_AXI_ID_WIDTH-1:0]   s_axi4_rid,
  output logic [C_AXI_DATA_WIDTH-1:0] s_axi4_rdata,
  output logic [1:0]                  s_axi4_rresp,
  output logic                        s_axi4_rlast,
  output logic [C_AXI_USER_WIDTH-1:0] s_axi4_ruser,
  output logic                        s_axi4_rvalid,
  input  logic                        s_axi4_rready,
  output rrch_state_e                 dbg_state
);
  localparam int IW = C_AXI_ID_WIDTH;
  localparam int UW = C_AXI_USER_WIDTH;
  localparam int FW = IW + UW + 2 + 8;

  rrch_state_e   state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [FW-1:0] push_data, head;
  logic          fifo_full, fifo_empty, fifo_pop;
  logic [7:0]    head_len;
  logic [1:0]    head_resp;
  logic [UW-1:0] head_user;
  logic [IW-1:0] head_id;
  logic          err_last;

  // drop_ready depends only on queue occupancy, never on drop_valid.
  assign drop_ready = !fifo_full;
  assign push_data  = {drop_id, drop_user, drop_resp, drop_len};
  assign {head_id, head_user, head_resp, head_len} = head;
  assign err_last   = (cnt_q == head_len);
  assign dbg_state  = state_q;

  axi4_drop_fifo #(.WIDTH(FW), .DEPTH(C_DROP_DEPTH)) u_drop_fifo (
    .clk   (axi4_aclk),
    .rst_n (axi4_arstn),
    .push  (drop_valid && !fifo_full),
    .wdata (push_data),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty)        state_d = ST_ERR;
        else if (m_axi4_rvalid) state_d = ST_PASS;
      end
      ST_PASS: begin
        if (m_axi4_rvalid && s_axi4_rready && m_axi4_rlast) state_d = ST_IDLE;
      end
      ST_ERR: begin
        if (s_axi4_rready) begin
          if (err_last) begin
            fifo_pop = 1'b1;
            cnt_d    = 8'd0;
            state_d  = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output mux: all selects come from flops, so ERR beats hold while stalled.
  always_comb begin
    s_axi4_rid    = '0;
    s_axi4_rdata  = '0;
    s_axi4_rresp  = RESP_OKAY;
    s_axi4_rlast  = 1'b0;
    s_axi4_ruser  = '0;
    s_axi4_rvalid = 1'b0;
    m_axi4_rready = 1'b0;
    case (state_q)
      ST_PASS: begin
        s_axi4_rid    = m_axi4_rid;
        s_axi4_rdata  = m_axi4_rdata;
        s_axi4_rresp  = m_axi4_rresp;
        s_axi4_rlast  = m_axi4_rlast;
        s_axi4_ruser  = m_axi4_ruser;
        s_axi4_rvalid = m_axi4_rvalid;
        m_axi4_rready = s_axi4_rready;
      end
      ST_ERR: begin
        s_axi4_rid    = head_id;
        s_axi4_rresp  = head_resp;
        s_axi4_rlast  = err_last;
        s_axi4_ruser  = head_user;
        s_axi4_rvalid = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_axi4_rrch_sender.sv
// Directed bench for axi4_rrch_sender: expected beats are queued at stimulus
// time and a negedge monitor pops and compares every accepted output beat.
module tb_axi4_rrch_sender;
  import axi_rab_pkg::*;

  localparam int DW = 32;
  localparam int IW = 4;
  localparam int UW = 4;
  localparam int BW = IW + DW + 2 + 1 + UW;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4_rrch_sender_if #(.DW(DW), .IW(IW), .UW(UW)) m_if ();
  axi4_rrch_sender_if #(.DW(DW), .IW(IW), .UW(UW)) s_if ();

  logic          drop_valid = 1'b0;
  logic          drop_ready;
  logic [IW-1:0] drop_id = '0;
  logic [7:0]    drop_len = '0;
  logic [UW-1:0] drop_user = '0;
  logic [1:0]    drop_resp = '0;
  rrch_state_e   dbg_state;
  logic          rdy_mode = 1'b0;

  axi4_rrch_sender #(
    .C_AXI_DATA_WIDTH(DW), .C_AXI_ID_WIDTH(IW), .C_AXI_USER_WIDTH(UW), .C_DROP_DEPTH(2)
  ) dut (
    .axi4_aclk     (clk),
    .axi4_arstn    (rst_n),
    .drop_valid    (drop_valid),
    .drop_ready    (drop_ready),
    .drop_id       (drop_id),
    .drop_len      (drop_len),
    .drop_user     (drop_user),
    .drop_resp     (drop_resp),
    .m_axi4_rid    (m_if.rid),
    .m_axi4_rdata  (m_if.rdata),
    .m_axi4_rresp  (m_if.rresp),
    .m_axi4_rlast  (m_if.rlast),
    .m_axi4_ruser  (m_if.ruser),
    .m_axi4_rvalid (m_if.rvalid),
    .m_axi4_rready (m_if.rready),
    .s_axi4_rid    (s_if.rid),
    .s_axi4_rdata  (s_if.rdata),
    .s_axi4_rresp  (s_if.rresp),
    .s_axi4_rlast  (s_if.rlast),
    .s_axi4_ruser  (s_if.ruser),
    .s_axi4_rvalid (s_if.rvalid),
    .s_axi4_rready (s_if.rready),
    .dbg_state     (dbg_state)
  );

  // scoreboard
  logic [BW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int obs_cnt = 0;

  function automatic logic [BW-1:0] pack(input logic [IW-1:0] id, input logic [DW-1:0] data,
                                         input logic [1:0] resp, input logic last,
                                         input logic [UW-1:0] user);
    return {id, data, resp, last, user};
  endfunction

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ready generator: constant 1, or toggling every cycle for backpressure
  initial begin
    s_if.rready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      s_if.rready = rdy_mode ? ~s_if.rready : 1'b1;
    end
  end

  // monitor
  logic          prev_stall = 1'b0;
  logic [BW-1:0] prev_beat = '0;
  logic [BW-1:0] cur_beat;
  always @(negedge clk) begin
    cur_beat = pack(s_if.rid, s_if.rdata, s_if.rresp, s_if.rlast, s_if.ruser);
    if (rst_n) begin
      if (prev_stall) begin
        check("stall_valid", 64'(s_if.rvalid), 64'd1);
        check("stall_hold", 64'(cur_beat), 64'(prev_beat));
      end
      if (s_if.rvalid && s_if.rready) begin
        obs_cnt++;
        if (exp_q.size() == 0) check("unexpected_beat", 64'(cur_beat), 64'h0);
        else check("beat", 64'(cur_beat), 64'(exp_q.pop_front()));
      end
      prev_stall = s_if.rvalid && !s_if.rready;
      prev_beat  = cur_beat;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // drivers
  task automatic slave_burst(input logic [IW-1:0] id, input int beats, input logic [DW-1:0] base);
    for (int i = 0; i < beats; i++)
      exp_q.push_back(pack(id, base + DW'(i), RESP_OKAY, i == beats - 1, UW'(i)));
    for (int i = 0; i < beats; i++) begin
      int n = 0;
      m_if.rvalid = 1'b1;
      m_if.rid    = id;
      m_if.rdata  = base + DW'(i);
      m_if.rresp  = RESP_OKAY;
      m_if.rlast  = (i == beats - 1);
      m_if.ruser  = UW'(i);
      forever begin
        @(negedge clk);
        if (m_if.rready) begin
          @(posedge clk); #1;
          break;
        end
        if (++n > 2000) begin
          check("m_accept_timeout", 64'(n), 64'd0);
          @(posedge clk); #1;
          break;
        end
      end
    end
    m_if.rvalid = 1'b0;
    m_if.rlast  = 1'b0;
  endtask

  task automatic drop_push_exp(input logic [IW-1:0] id, input logic [7:0] len,
                               input logic [UW-1:0] user, input logic [1:0] resp);
    for (int i = 0; i <= int'(len); i++)
      exp_q.push_back(pack(id, '0, resp, i == int'(len), user));
    drop_valid = 1'b1;
    drop_id    = id;
    drop_len   = len;
    drop_user  = user;
    drop_resp  = resp;
  endtask

  task automatic drop_wait_accept();
    int n = 0;
    forever begin
      @(negedge clk);
      if (drop_ready) begin
        @(posedge clk); #1;
        break;
      end
      if (++n > 2000) begin
        check("drop_accept_timeout", 64'(n), 64'd0);
        @(posedge clk); #1;
        break;
      end
    end
    drop_valid = 1'b0;
  endtask

  task automatic drop_req(input logic [IW-1:0] id, input logic [7:0] len,
                          input logic [UW-1:0] user, input logic [1:0] resp);
    drop_push_exp(id, len, user, resp);
    drop_wait_accept();
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    m_if.rvalid = 1'b0; m_if.rlast = 1'b0; m_if.rid = '0;
    m_if.rdata = '0; m_if.rresp = '0; m_if.ruser = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_rvalid", 64'(s_if.rvalid), 64'd0);
    check("rst_m_rready", 64'(m_if.rready), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_drop_ready", 64'(drop_ready), 64'd1);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));

    // passthrough 4 beats, id 3
    slave_burst(4'd3, 4, 32'hA000_0000);
    check("pass_state_idle", 64'(dbg_state), 64'(ST_IDLE));
    check("pass_m_rready", 64'(m_if.rready), 64'd0);
    wait_drain(50);

    // error burst len 3, id 5, SLVERR
    base = obs_cnt;
    drop_req(4'd5, 8'd3, 4'hA, RESP_SLVERR);
    wait_drain(50);
    check("err_beats", 64'(obs_cnt - base), 64'd4);

    // single-beat error burst
    drop_req(4'd1, 8'd0, 4'h2, RESP_DECERR);
    wait_drain(50);

    // drop request during beat 2 of an 8-beat passthrough
    base = obs_cnt;
    fork
      slave_burst(4'd2, 8, 32'hB000_0010);
      begin
        int n = 0;
        while (obs_cnt != base + 1 && n < 200) begin @(posedge clk); #1; n++; end
        drop_req(4'd7, 8'd1, 4'h3, RESP_DECERR);
      end
    join
    wait_drain(100);
    check("cont_beats", 64'(obs_cnt - base), 64'd10);

    // full queue: third request waits until the first burst completes
    base = obs_cnt;
    drop_req(4'd4, 8'd3, 4'h4, RESP_SLVERR);
    drop_req(4'd6, 8'd3, 4'h6, RESP_SLVERR);
    drop_push_exp(4'd8, 8'd0, 4'h8, RESP_DECERR);
    @(negedge clk);
    check("full_drop_ready", 64'(drop_ready), 64'd0);
    @(posedge clk); #1;
    drop_wait_accept();
    check("full_accept_after_first", 64'(obs_cnt - base), 64'd4);
    wait_drain(100);

    // backpressure on a 256-beat error burst
    base = obs_cnt;
    rdy_mode = 1'b1;
    drop_req(4'd9, 8'd255, 4'h5, RESP_DECERR);
    wait_drain(2000);
    rdy_mode = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("bp_beats", 64'(obs_cnt - base), 64'd256);

    // reset in the middle of an error burst
    base = obs_cnt;
    drop_req(4'd6, 8'd7, 4'h1, RESP_SLVERR);
    begin
      int n = 0;
      while (obs_cnt != base + 2 && n < 200) begin @(posedge clk); #1; n++; end
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_s_rvalid", 64'(s_if.rvalid), 64'd0);
    check("mid_rst_m_rready", 64'(m_if.rready), 64'd0);
    check("mid_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_s_rvalid", 64'(s_if.rvalid), 64'd0);
    check("post_rst_drop_ready", 64'(drop_ready), 64'd1);
    check("post_rst_state", 64'(dbg_state), 64'(ST_IDLE));

    check("final_exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axi4_rrch_sender.md
AXI4_RRCH_SENDER -- requirements
Module: axi4_rrch_sender

Interface
REQ-001 SHALL have parameter C_AXI_DATA_WIDTH, default 32, R data width.
REQ-002 SHALL have parameter C_AXI_ID_WIDTH, default 4, R ID width.
REQ-003 SHALL have parameter C_AXI_USER_WIDTH, default 4, R user width.
REQ-004 SHALL have parameter C_DROP_DEPTH, default 2, drop-request queue entries (power of two, at least 2).
REQ-005 SHALL use one clock, axi4_aclk, and an asynchronous active-low reset, axi4_arstn; port lines follow as name, direction, width, meaning.
REQ-006 axi4_aclk  in  1  clock, all state rising-edge.
REQ-007 axi4_arstn  in  1  asynchronous active-low reset.
REQ-008 drop_valid  in  1  error-burst request valid.
REQ-009 drop_ready  out  1  request accepted when high with drop_valid.
REQ-010 drop_id  in  C_AXI_ID_WIDTH  ID for the error burst.
REQ-011 drop_len  in  8  AXI ARLEN; the burst is drop_len+1 beats.
REQ-012 drop_user  in  C_AXI_USER_WIDTH  ruser for error beats.
REQ-013 drop_resp  in  2  rresp for error beats (2'b10 or 2'b11).
REQ-014 m_axi4_rid, m_axi4_rdata, m_axi4_rresp, m_axi4_rlast, m_axi4_ruser, m_axi4_rvalid  in  widths per parameters  R channel from the downstream slave.
REQ-015 m_axi4_rready  out  1  ready to the downstream slave.
REQ-016 s_axi4_rid, s_axi4_rdata, s_axi4_rresp, s_axi4_rlast, s_axi4_ruser, s_axi4_rvalid  out  widths per parameters  merged R channel toward the R buffer.
REQ-017 s_axi4_rready  in  1  ready from the R buffer.

Function
REQ-018 SHALL queue drop requests in a FIFO of C_DROP_DEPTH entries; drop_ready SHALL equal "not full", with no combinational path from drop_valid.
REQ-019 SHALL implement the FSM states IDLE, PASS and ERR.
REQ-020 In IDLE, if the queue is non-empty the FSM SHALL go to ERR (error bursts have priority); otherwise, if m_axi4_rvalid is high, it SHALL go to PASS.
REQ-021 IDLE SHALL drive s_axi4_rvalid=0 and m_axi4_rready=0.
REQ-022 In PASS, s_axi4_r* SHALL equal m_axi4_r* combinationally and m_axi4_rready SHALL equal s_axi4_rready.
REQ-023 PASS SHALL return to IDLE on the beat where s_axi4_rvalid, s_axi4_rready and m_axi4_rlast are all high.
REQ-024 Error beats SHALL never interleave within a passthrough burst.
REQ-025 In ERR, the block SHALL drive s_axi4_rvalid=1, rdata=0, rid=head drop_id, ruser=head drop_user and rresp=head drop_resp, with m_axi4_rready=0.
REQ-026 In ERR, an 8-bit beat counter SHALL start at 0 and increment on each accepted beat; s_axi4_rlast=1 exactly when counter==drop_len.
REQ-027 On the accepted last error beat, the block SHALL pop the queue, clear the counter and return to IDLE; there SHALL be one idle cycle between bursts.
REQ-028 drop_len=0 SHALL produce a single beat with rlast=1; drop_len=255 SHALL produce 256 beats with no counter wrap.
REQ-029 Output fields SHALL hold stable while s_axi4_rvalid=1 and s_axi4_rready=0.
REQ-030 A simultaneous push and pop SHALL be allowed when the queue is full, but drop_ready SHALL still read 0 that cycle.

Reset
REQ-031 Assertion of axi4_arstn SHALL immediately set the FSM to IDLE, clear the counter and empty the queue, including mid-burst.
REQ-032 During and after reset, s_axi4_rvalid=0, m_axi4_rready=0 and drop_ready=1 (the latter once reset is released).

Structure
REQ-033 The FSM state enum and the error response codes (SLVERR, DECERR) SHALL live in the shared axi_rab package.
REQ-034 The drop queue SHALL be a single sub-module, axi4_drop_fifo, parameterised by width and depth.

Verification
REQ-035 Passthrough: 4-beat slave burst id=3 with s_axi4_rready=1 -> 4 identical beats out, rlast on beat 4, FSM back to IDLE.
REQ-036 Error burst: drop_len=3, id=5, resp=2'b10 -> 4 beats, rdata=0, rresp=2'b10, rid=5, rlast on beat 4 only.
REQ-037 Contention: drop request arrives during beat 2 of an 8-beat passthrough -> the 8 passthrough beats complete, then the error burst follows.
REQ-038 Backpressure: s_axi4_rready toggled 1/0 during an error burst with drop_len=255 -> exactly 256 beats, outputs stable while stalled.
REQ-039 Full queue: with C_DROP_DEPTH=2, 3 back-to-back drop requests -> drop_ready=0 on the third request until the first error burst completes.
REQ-040 Reset during ERR at beat 2 -> s_axi4_rvalid=0 immediately and the queue is empty afterwards.
